// File: rtl/nn_pkg.sv
// Shared definitions for the input-layer pixel feed: FSM states, fixed-point constants, width defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_pkg;

    // Default fixed-point sample width and binary pixels per input word
    localparam int DWIDTH_DEF = 16;
    localparam int IWIDTH_DEF = 64;

    // Fixed-point 1.0 (Q6.9 style: bit 9 is the unit bit)
    localparam logic [15:0] FX_ONE = 16'h0200;

    // Feed controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/convert_k.sv
// Converts one binary pixel into a fixed-point sample (1 -> FX_ONE, 0 -> zero).
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module convert_k
    import nn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
)(
    input  logic              bit_in,
    output logic [DWIDTH-1:0] k_out
);

    assign k_out = bit_in ? DWIDTH'(FX_ONE) : '0;

endmodule

// File: rtl/pixel_feed_ctrl.sv
// Unpacks binary pixel words MSB-first into a stream of fixed-point samples for the input layer.
// Latency: first sample valid one cycle after word acceptance; one sample/cycle, one bubble per word.
// Backpressure: k_ready low freezes the sample (k_out/k_idx/k_last held); in_ready only high in FETCH.
module pixel_feed_ctrl
    import nn_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int IWIDTH = IWIDTH_DEF,
    parameter int NWORDS = 4,
    parameter int IDXW   = 8
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IWIDTH-1:0] in_word,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DWIDTH-1:0] k_out,
    output logic              k_valid,
    input  logic              k_ready,
    output logic [IDXW-1:0]   k_idx,
    output logic              k_last,
    output logic              busy,
    output logic              done
);

    localparam int BW = (IWIDTH > 1) ? $clog2(IWIDTH) : 1;
    localparam int WW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [BW-1:0] BIT_MAX  = BW'(IWIDTH - 1);
    localparam logic [WW-1:0] WORD_MAX = WW'(NWORDS - 1);

    feed_state_t       state;
    logic [IWIDTH-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [WW-1:0]     word_cnt;

    // Final pixel of the frame: decoded from registered counters, so it holds across stalls
    assign k_last = k_valid && (bit_cnt == BIT_MAX) && (word_cnt == WORD_MAX);

    // Frame sequencing: word fetch, per-pixel emit with backpressure, end-of-frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            k_idx    <= '0;
            in_ready <= 1'b0;
            k_valid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        word_cnt <= '0;
                        k_idx    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (in_valid && in_ready) begin
                        shreg    <= in_word;
                        bit_cnt  <= '0;
                        in_ready <= 1'b0;
                        k_valid  <= 1'b1;
                        state    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (k_ready) begin
                        shreg <= shreg << 1;
                        if (bit_cnt == BIT_MAX) begin
                            k_valid <= 1'b0;
                            if (word_cnt == WORD_MAX) begin
                                // Index wraps here so the DONE cycle already shows 0
                                state <= ST_DONE;
                                done  <= 1'b1;
                                k_idx <= '0;
                            end else begin
                                word_cnt <= word_cnt + 1'b1;
                                k_idx    <= k_idx + 1'b1;
                                in_ready <= 1'b1;
                                state    <= ST_FETCH;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            k_idx   <= k_idx + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    k_valid  <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Sample value comes straight from the current head of the shift register
    convert_k #(
        .DWIDTH (DWIDTH)
    ) u_convert_k (
        .bit_in (shreg[IWIDTH-1]),
        .k_out  (k_out)
    );

endmodule

// File: tb/tb_pixel_feed_ctrl.sv
// Self-checking bench for pixel_feed_ctrl: table of frame scenarios driven with random stalls/gaps.
// Latency: checks first-sample latency, done timing and one-cycle idle gap between frames.
// Backpressure: random k_ready stalls with hold-stability checks; in_valid gaps in FETCH.
module tb_pixel_feed_ctrl;
    import nn_pkg::*;

    localparam int DW   = 16;
    localparam int IW   = 64;
    localparam int NW   = 4;
    localparam int IXW  = 8;
    localparam int NPIX = IW * NW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [IW-1:0]   in_word;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   k_out;
    logic            k_valid;
    logic            k_ready;
    logic [IXW-1:0]  k_idx;
    logic            k_last;
    logic            busy;
    logic            done;

    int checks   = 0;
    int failures = 0;

    pixel_feed_ctrl #(
        .DWIDTH (DW),
        .IWIDTH (IW),
        .NWORDS (NW),
        .IDXW   (IXW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_word  (in_word),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .k_out    (k_out),
        .k_valid  (k_valid),
        .k_ready  (k_ready),
        .k_idx    (k_idx),
        .k_last   (k_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One frame scenario: stimulus knobs plus the outcome the frame must produce
    typedef struct {
        logic [NPIX-1:0] frame;      // word 0 in the top IW bits, pixel 0 is the very top bit
        int              stall_pct;  // chance (%) of k_ready low per cycle
        int              gap_pct;    // chance (%) of in_valid withheld per cycle
        int              hold;       // cycles in_valid is forced low right after start
        int              mid_start;  // sample count at which start is re-pulsed (-1: never)
        int              abort_at;   // sample index at which rst is asserted (-1: never)
        int              exp_samples;
        int              exp_ones;
        int              exp_done;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference: pixel i is bit (NPIX-1-i) of the frame, mapped to 1.0 or 0.0
    function automatic logic [DW-1:0] ref_pixel(input logic [NPIX-1:0] fr, input int i);
        return fr[NPIX-1-i] ? 16'h0200 : 16'h0000;
    endfunction

    function automatic int ref_ones(input logic [NPIX-1:0] fr, input int count);
        int c = 0;
        for (int b = 0; b < count; b++)
            if (fr[NPIX-1-b]) c++;
        return c;
    endfunction

    // Runs one frame starting from IDLE at a negedge; returns at a negedge in IDLE
    task automatic run_frame(input vec_t v, output int n, output int ones, output int dcnt);
        int            wi;
        int            last_xfer;
        int            acc_cyc;
        bit            stall_prev;
        bit            aborted;
        bit            finished;
        logic [DW-1:0] s_out;
        logic [IXW-1:0] s_idx;
        logic          s_last;
        n = 0; ones = 0; dcnt = 0; wi = 0;
        last_xfer = -10; acc_cyc = -10;
        stall_prev = 1'b0; aborted = 1'b0; finished = 1'b0;
        s_out = '0; s_idx = '0; s_last = 1'b0;

        chk("idle_busy_before_start", busy, 1'b0);
        start    = 1'b1;
        in_valid = 1'b0;
        k_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;

        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (cyc == 0) chk("busy_after_start", busy, 1'b1);
            if (cyc < v.hold) begin
                chk("hold_in_ready", in_ready, 1'b1);
                chk("hold_k_valid", k_valid, 1'b0);
                chk("hold_k_idx", k_idx, 0);
            end
            if (acc_cyc == cyc - 1) begin
                chk("first_k_valid_latency", k_valid, 1'b1);
                chk("in_ready_drop", in_ready, 1'b0);
            end
            if (in_ready) chk("fetch_no_k_valid", k_valid, 1'b0);
            if (stall_prev) begin
                chk("stall_k_valid", k_valid, 1'b1);
                chk("stall_k_out", k_out, s_out);
                chk("stall_k_idx", k_idx, s_idx);
                chk("stall_k_last", k_last, s_last);
            end
            if (done) begin
                dcnt++;
                chk("done_after_last", last_xfer, cyc - 1);
                chk("done_idx_wrap", k_idx, 0);
                chk("done_busy", busy, 1'b1);
                chk("done_k_valid", k_valid, 1'b0);
            end
            if (dcnt > 0 && !done) begin
                finished = 1'b1;
                break;
            end
            if (v.abort_at >= 0 && k_valid && n == v.abort_at) begin
                chk("abort_idx", k_idx, v.abort_at);
                #2 rst = 1'b1;
                #1;
                chk("async_rst_k_valid", k_valid, 1'b0);
                chk("async_rst_in_ready", in_ready, 1'b0);
                chk("async_rst_k_out", k_out, 0);
                chk("async_rst_k_idx", k_idx, 0);
                chk("async_rst_k_last", k_last, 1'b0);
                chk("async_rst_busy", busy, 1'b0);
                chk("async_rst_done", done, 1'b0);
                in_valid = 1'b0;
                k_ready  = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                chk("no_done_after_abort", done, 1'b0);
                aborted  = 1'b1;
                finished = 1'b1;
                break;
            end

            // Drive this cycle's inputs
            k_ready = ($urandom_range(99) >= v.stall_pct);
            start   = (v.mid_start >= 0 && n == v.mid_start && k_valid);
            if (wi < NW && cyc >= v.hold && $urandom_range(99) >= v.gap_pct) begin
                in_valid = 1'b1;
                in_word  = v.frame[NPIX-1-wi*IW -: IW];
            end else begin
                in_valid = 1'b0;
                in_word  = {$urandom, $urandom};
            end

            if (in_valid && in_ready) begin
                wi++;
                acc_cyc = cyc;
            end
            if (k_valid && k_ready) begin
                chk("k_idx", k_idx, n);
                chk("k_out", k_out, ref_pixel(v.frame, n));
                chk("k_last", k_last, (n == NPIX - 1));
                if (k_out == 16'h0200) ones++;
                n++;
                last_xfer = cyc;
            end
            stall_prev = k_valid && !k_ready;
            s_out  = k_out;
            s_idx  = k_idx;
            s_last = k_last;

            @(posedge clk);
            @(negedge clk);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("frame_finished_in_budget", finished, 1'b1);
        if (!aborted) begin
            chk("idle_busy_between", busy, 1'b0);
            chk("idle_done_low", done, 1'b0);
            chk("idle_k_idx", k_idx, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, ones, dcnt;
        logic [NPIX-1:0] f30;
        logic [NPIX-1:0] fr;

        f30 = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
               64'hAAAA_AAAA_AAAA_AAAA, 64'h8000_0000_0000_0001};
        vecs[0] = '{f30,  0,  0,  0, -1,  -1, 256, 98, 1};
        vecs[1] = '{f30, 50,  0,  0, -1,  -1, 256, 98, 1};
        vecs[2] = '{f30, 25, 20,  0, 50,  -1, 256, 98, 1};
        for (int r = 3; r < 6; r++) begin
            for (int w = 0; w < NPIX / 32; w++) fr[w*32 +: 32] = $urandom;
            vecs[r].frame = fr;
        end
        vecs[3] = '{vecs[3].frame, 30,  0, 10, -1, 100, 100, ref_ones(vecs[3].frame, 100), 0};
        vecs[4] = '{vecs[4].frame, 40, 40,  0, -1,  -1, 256, ref_ones(vecs[4].frame, NPIX), 1};
        vecs[5] = '{vecs[5].frame,  0,  0,  0, -1,  -1, 256, ref_ones(vecs[5].frame, NPIX), 1};

        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        k_ready  = 1'b0;
        in_word  = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_k_valid", k_valid, 1'b0);
        chk("reset_k_out", k_out, 0);
        chk("reset_k_idx", k_idx, 0);
        chk("reset_k_last", k_last, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i], n, ones, dcnt);
            chk($sformatf("vec%0d_samples", i), n, vecs[i].exp_samples);
            chk($sformatf("vec%0d_ones", i), ones, vecs[i].exp_ones);
            chk($sformatf("vec%0d_done_count", i), dcnt, vecs[i].exp_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_feed_ctrl.md
PIXEL_FEED_CTRL -- requirements
Module: pixel_feed_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, fixed-point sample width.
REQ-002 SHALL have parameter IWIDTH, default 64, binary pixels per input word.
REQ-003 SHALL have parameter NWORDS, default 4, input words per frame; frame = IWIDTH*NWORDS pixels.
REQ-004 SHALL have parameter IDXW, default 8, width of pixel index (>= clog2(IWIDTH*NWORDS)).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port start, input, 1, one-cycle frame start request.
REQ-008 SHALL have port in_word, input, IWIDTH, packed binary pixels; bit IWIDTH-1 is the first pixel.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1), word handshake.
REQ-010 SHALL have port k_out, output, DWIDTH, fixed-point pixel: 0x0200 (1.0) for bit 1, 0x0000 for bit 0.
REQ-011 SHALL have ports k_valid (output, 1) and k_ready (input, 1), sample handshake to the input layer.
REQ-012 SHALL have port k_idx, output, IDXW, pixel index 0..IWIDTH*NWORDS-1 of k_out.
REQ-013 SHALL have port k_last, output, 1, high with the final pixel of a frame.
REQ-014 SHALL have ports busy (output, 1; high outside IDLE) and done (output, 1; one-cycle pulse at frame end).

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> EMIT -> (FETCH | DONE) -> IDLE.
REQ-016 IDLE: in_ready=0, k_valid=0; start=1 -> FETCH, word_cnt=0, k_idx=0.
REQ-017 FETCH: in_ready=1; on in_valid&in_ready latch in_word into shift register, bit_cnt=0 -> EMIT.
REQ-018 EMIT: k_valid=1, k_out derived combinationally from shift register MSB; first k_valid exactly one cycle after word acceptance.
REQ-019 On k_valid&k_ready: shift left by 1, bit_cnt+1, k_idx+1; one pixel per cycle max throughput within a word.
REQ-020 When k_valid&!k_ready, k_out, k_idx, k_last SHALL hold stable.
REQ-021 Transfer with bit_cnt==IWIDTH-1: if word_cnt==NWORDS-1 -> DONE, else word_cnt+1 -> FETCH (one bubble cycle per word).
REQ-022 k_last=1 only when bit_cnt==IWIDTH-1 and word_cnt==NWORDS-1 in EMIT.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE; k_idx wraps to 0.
REQ-024 start SHALL be ignored outside IDLE; in_word SHALL be ignored outside FETCH.
REQ-025 Counters SHALL never exceed IWIDTH-1 / NWORDS-1; no wrap mid-frame.

Reset
REQ-026 rst=1 SHALL asynchronously force IDLE, shift register=0, counters=0, k_idx=0, done=0, in_ready=0, k_valid=0, k_out=0x0000.
REQ-027 rst mid-frame SHALL abandon the frame; no done pulse; next frame restarts at k_idx=0.

Structure
REQ-028 FSM state encoding, fixed-point ONE constant (0x0200), DWIDTH/IWIDTH defaults SHALL live in shared package nn_pkg.
REQ-029 k_out SHALL come from one instance of the existing 1-bit-to-fixed converter convert_k fed by the shift-register MSB; no other sub-modules.

Verification
REQ-030 IWIDTH=64, NWORDS=4, words 0xFFFF..FF, 0x0, 0xAAAA..AA, 0x8000..01, k_ready=1 -> 256 samples, idx 0..255, values 0x0200x64, 0x0000x64, alternating 0x0200/0x0000, then 0x0200, 62x0x0000, 0x0200; k_last at idx 255; done one cycle later.
REQ-031 Random k_ready stalls (50%) -> k_out/k_idx stable across every stall; sequence identical to REQ-030.
REQ-032 in_valid withheld 10 cycles in FETCH -> in_ready stays 1, k_valid stays 0, no index advance.
REQ-033 start pulsed during EMIT -> ignored; frame completes with exactly 256 samples and one done.
REQ-034 rst asserted at idx 100 -> all outputs reset same cycle (async); new start -> first sample idx 0.
REQ-035 Back-to-back frames (start in cycle after done) -> second frame idx restarts at 0, busy low exactly one cycle between frames.
